control_juego: RTL and testbench
================================

CONTROL_JUEGO -- requirements
Module: control_juego

Interface
REQ-001 Parameter GOAL, default 2048, tile value that wins the game.
REQ-002 Parameter SEED, default 16'hACE1, LFSR reset value; must be nonzero.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 btn_valid  in  1  one-cycle move request strobe.
REQ-006 btn_dir  in  3  move code: 001 up, 010 down, 011 left, 100 right.
REQ-007 mov_sel  out  3  selector driven to the combinational movement datapath.
REQ-008 mov_in  out  256  board presented to the datapath; equals board.
REQ-009 mov_out  in  256  datapath result, combinational from mov_in/mov_sel.
REQ-010 board  out  256  registered board; cell (r,c) at bits [(r*4+c)*16 +: 16]; 0 = empty.
REQ-011 busy  out  1  high in every state except IDLE, WIN, LOSE.
REQ-012 gano / perdio  out  1 each  win / loss flags.
REQ-013 move_count  out  16  count of accepted board-changing moves, saturating at 16'hFFFF.

Function
REQ-014 The FSM SHALL have states INIT_A, INIT_B, IDLE, APPLY, SPAWN, CHECK, WIN, LOSE.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle, including while busy.
REQ-016 mov_sel SHALL be the latched direction in APPLY and 3'b000 in all other states.
REQ-017 IDLE: btn_valid=1 with a legal code latches btn_dir -> APPLY; illegal codes, or btn_valid in any non-IDLE state, are ignored with no effect.
REQ-018 APPLY lasts exactly 1 cycle: if mov_out == board -> IDLE, board and move_count unchanged; otherwise board <= mov_out, move_count++ (saturating), scan pointer <= lfsr[3:0] -> SPAWN.
REQ-019 SPAWN inspects one cell per cycle at the pointer. If the cell is empty, it writes 4 when lfsr[7:4]==0, else 2, and exits. If the cell is occupied, pointer <= (pointer+1) mod 16. After 16 cells are inspected without finding an empty cell, it exits without writing.
REQ-020 SPAWN exit target SHALL be CHECK after a move, INIT_B from INIT_A, IDLE from INIT_B.
REQ-021 INIT_A/INIT_B reuse the SPAWN scan with pointer loaded from lfsr[3:0] on entry; two tiles are placed before the first IDLE.
REQ-022 CHECK lasts 1 cycle: any cell >= GOAL -> WIN; else no empty cell and no horizontally/vertically adjacent equal pair -> LOSE; else -> IDLE. Win has priority over loss.
REQ-023 WIN holds gano=1, LOSE holds perdio=1; both are terminal until rst.
REQ-024 Latency: an unchanged move returns to IDLE 2 cycles after the btn_valid edge; a changed move returns in 3+k+1 cycles, where k (0..15) is the number of occupied cells skipped.

Reset
REQ-025 While rst=1: board=0, move_count=0, gano=0, perdio=0, mov_sel=000, lfsr=SEED, state=INIT_A. Outputs SHALL be valid from the first edge with rst high.
REQ-026 rst asserted in any state, including mid-SPAWN or WIN/LOSE, SHALL abort the current operation on that edge with no partial tile write.

Verification
REQ-027 rst high 2 cycles, then low -> busy falls within 34 cycles; exactly 2 nonzero cells, each 2 or 4; gano=perdio=0; move_count=0.
REQ-028 In IDLE, btn_valid with btn_dir=011 and a bench datapath echoing mov_in -> mov_sel=011 for exactly 1 cycle; IDLE 2 cycles later; board and move_count unchanged.
REQ-029 mov_out = board with cell 0 = 4 and all others 0 -> board holds 4 at cell 0 plus one new 2/4 tile in an empty cell; move_count=1; state IDLE; gano=perdio=0.
REQ-030 mov_out containing 2048 at cell 5 -> gano=1 after CHECK; later btn_valid pulses change nothing; rst clears gano.
REQ-031 mov_out full except cell 0, no equal adjacent pair, cells 1 and 4 = 8 -> tile placed at cell 0; perdio=1; gano=0.
REQ-032 btn_valid pulsed during SPAWN is ignored; rst asserted mid-SPAWN -> board=0 next cycle and INIT_A re-runs.

Source files
------------

// File: rtl/control_juego.sv
// control_juego: sequencer for a 4x4 sliding-tile game. It owns the board
// register, accepts one move request at a time, hands the board to an
// external combinational movement datapath, spawns new tiles from an LFSR,
// and flags win or loss.
//
// Move handshake: btn_valid is a one-cycle strobe with no ready return. A
// strobe is taken only while the FSM sits in IDLE (busy low) with a legal
// btn_dir. Any other strobe is dropped and has no effect.
module control_juego #(
  parameter int unsigned GOAL = 2048,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_valid,
  input  logic [2:0]   btn_dir,
  output logic [2:0]   mov_sel,
  output logic [255:0] mov_in,
  input  logic [255:0] mov_out,
  output logic [255:0] board,
  output logic         busy,
  output logic         gano,
  output logic         perdio,
  output logic [15:0]  move_count,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    S_INIT_A = 3'd0,
    S_INIT_B = 3'd1,
    S_IDLE   = 3'd2,
    S_APPLY  = 3'd3,
    S_SPAWN  = 3'd4,
    S_CHECK  = 3'd5,
    S_WIN    = 3'd6,
    S_LOSE   = 3'd7
  } state_e;

  // Where the shared spawn scan goes when it finishes.
  typedef enum logic [1:0] {
    RET_INIT_B = 2'd0,
    RET_IDLE   = 2'd1,
    RET_CHECK  = 2'd2
  } ret_e;

  state_e         state_q, state_d;
  ret_e           ret_q, ret_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [255:0]   board_q, board_d;
  logic [15:0]    mc_q, mc_d;
  logic [2:0]     dir_q, dir_d;
  logic [3:0]     ptr_q, ptr_d;
  logic [3:0]     scan_q, scan_d;
  logic [2:0]     mov_sel_q, mov_sel_d;
  logic           busy_q, busy_d;
  logic           gano_q, gano_d;
  logic           perdio_q, perdio_d;

  logic [15:0]    cells [16];
  logic           any_win, any_empty, any_pair;
  logic           dir_legal;
  state_e         spawn_exit;

  // Unpack the board into per-cell values.
  always_comb begin
    for (int i = 0; i < 16; i++) cells[i] = board_q[i*16 +: 16];
  end

  // End-of-move board analysis: goal reached, free cell, mergeable neighbours.
  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (32'(cells[i]) >= GOAL) any_win = 1'b1;
      if (cells[i] == 16'd0) any_empty = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (cells[r*4+c] == cells[r*4+c+1]) any_pair = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (cells[i] == cells[i+4]) any_pair = 1'b1;
    end
  end

  // Decode the spawn return target and the legality of the requested move.
  always_comb begin
    case (ret_q)
      RET_INIT_B: spawn_exit = S_INIT_B;
      RET_IDLE:   spawn_exit = S_IDLE;
      default:    spawn_exit = S_CHECK;
    endcase
    dir_legal = (btn_dir == 3'b001) || (btn_dir == 3'b010) ||
                (btn_dir == 3'b011) || (btn_dir == 3'b100);
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    board_d  = board_q;
    mc_d     = mc_q;
    dir_d    = dir_q;
    ptr_d    = ptr_q;
    scan_d   = scan_q;
    gano_d   = gano_q;
    perdio_d = perdio_q;
    // Free-running: the tile position and value depend on how long play took.
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_INIT_A: begin
        ptr_d   = lfsr_q[3:0];
        scan_d  = 4'd0;
        ret_d   = RET_INIT_B;
        state_d = S_SPAWN;
      end
      S_INIT_B: begin
        ptr_d   = lfsr_q[3:0];
        scan_d  = 4'd0;
        ret_d   = RET_IDLE;
        state_d = S_SPAWN;
      end
      S_IDLE: begin
        if (btn_valid && dir_legal) begin
          dir_d   = btn_dir;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (mov_out == board_q) begin
          state_d = S_IDLE;
        end else begin
          board_d = mov_out;
          mc_d    = (mc_q == 16'hFFFF) ? mc_q : mc_q + 16'd1;
          ptr_d   = lfsr_q[3:0];
          scan_d  = 4'd0;
          ret_d   = RET_CHECK;
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (cells[ptr_q] == 16'd0) begin
          board_d[{ptr_q, 4'b0000} +: 16] = (lfsr_q[7:4] == 4'd0) ? 16'd4 : 16'd2;
          state_d = spawn_exit;
        end else begin
          ptr_d  = ptr_q + 4'd1;
          scan_d = scan_q + 4'd1;
          // Sixteenth occupied cell: board is full, leave without a tile.
          if (scan_q == 4'd15) state_d = spawn_exit;
        end
      end
      S_CHECK: begin
        if (any_win) begin
          gano_d  = 1'b1;
          state_d = S_WIN;
        end else if (!any_empty && !any_pair) begin
          perdio_d = 1'b1;
          state_d  = S_LOSE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WIN:  state_d = S_WIN;
      S_LOSE: state_d = S_LOSE;
      default: state_d = S_INIT_A;
    endcase

    mov_sel_d = (state_d == S_APPLY) ? dir_d : 3'b000;
    busy_d    = !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
  end

  // State and output registers; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT_A;
      ret_q     <= RET_INIT_B;
      lfsr_q    <= SEED;
      board_q   <= '0;
      mc_q      <= '0;
      dir_q     <= '0;
      ptr_q     <= '0;
      scan_q    <= '0;
      mov_sel_q <= '0;
      busy_q    <= 1'b1;
      gano_q    <= 1'b0;
      perdio_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      lfsr_q    <= lfsr_d;
      board_q   <= board_d;
      mc_q      <= mc_d;
      dir_q     <= dir_d;
      ptr_q     <= ptr_d;
      scan_q    <= scan_d;
      mov_sel_q <= mov_sel_d;
      busy_q    <= busy_d;
      gano_q    <= gano_d;
      perdio_q  <= perdio_d;
    end
  end

  assign mov_sel    = mov_sel_q;
  assign mov_in     = board_q;
  assign board      = board_q;
  assign busy       = busy_q;
  assign gano       = gano_q;
  assign perdio     = perdio_q;
  assign move_count = mc_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_control_juego.sv
// Bench for control_juego: the bench owns the movement datapath (echo or a
// fixed result board), queues the expected outcome of each move, and a
// negedge monitor checks every busy->idle transition, reset cycle and idle cycle.
`timescale 1ns/1ps
module tb_control_juego;

  localparam logic [2:0] ST_INIT_A = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_SPAWN  = 3'd4;
  localparam logic [2:0] ST_WIN    = 3'd6;
  localparam logic [2:0] ST_LOSE   = 3'd7;

  typedef struct packed {
    logic [2:0]   state;
    logic         gano;
    logic         perdio;
    logic [15:0]  mc;
    logic         ref_prev;
    logic [255:0] ref_board;
    logic [4:0]   new_tiles;
    logic [2:0]   sel;
    logic [1:0]   sel_cnt;
    logic [5:0]   lat_min;
    logic [5:0]   lat_max;
  } exp_t;

  // clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_valid = 1'b0;
  logic [2:0]   btn_dir = 3'b000;
  logic [2:0]   mov_sel;
  logic [255:0] mov_in;
  logic [255:0] mov_out;
  logic [255:0] board;
  logic         busy, gano, perdio;
  logic [15:0]  move_count;
  logic [2:0]   state_dbg;

  logic         use_fixed = 1'b0;
  logic [255:0] fixed_board = '0;

  // bench movement datapath
  assign mov_out = use_fixed ? fixed_board : mov_in;

  always #5 clk = ~clk;

  control_juego #(.GOAL(2048), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_valid  (btn_valid),
    .btn_dir    (btn_dir),
    .mov_sel    (mov_sel),
    .mov_in     (mov_in),
    .mov_out    (mov_out),
    .board      (board),
    .busy       (busy),
    .gano       (gano),
    .perdio     (perdio),
    .move_count (move_count),
    .state_dbg  (state_dbg)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic         rst_s = 1'b1;
  logic         prev_busy = 1'b0;
  int           win_len = 0;
  int           sel_cnt = 0;
  logic [2:0]   sel_val = 3'b000;
  logic [255:0] snap = '0;
  logic [15:0]  snap_mc = '0;

  always @(posedge clk) rst_s <= rst;

  task automatic check_output();
    exp_t         e;
    logic [255:0] rb;
    logic [15:0]  c, r;
    int           kept_bad, new_cnt, new_bad;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_output: got busy fall in state %0d, expected none queued", state_dbg);
      return;
    end
    e = exp_q.pop_front();
    chk("end_state", 32'(state_dbg), 32'(e.state));
    chk("gano", 32'(gano), 32'(e.gano));
    chk("perdio", 32'(perdio), 32'(e.perdio));
    chk("move_count", 32'(move_count), 32'(e.mc));
    rb = e.ref_prev ? snap : e.ref_board;
    kept_bad = 0;
    new_cnt  = 0;
    new_bad  = 0;
    for (int i = 0; i < 16; i++) begin
      c = board[i*16 +: 16];
      r = rb[i*16 +: 16];
      if (r != 16'd0) begin
        if (c != r) kept_bad++;
      end else if (c != 16'd0) begin
        new_cnt++;
        if (c != 16'd2 && c != 16'd4) new_bad++;
      end
    end
    chk("kept_cells_wrong", 32'(kept_bad), 32'd0);
    chk("new_tiles", 32'(new_cnt), 32'(e.new_tiles));
    chk("new_tile_value_bad", 32'(new_bad), 32'd0);
    chk("sel_cycles", 32'(sel_cnt), 32'(e.sel_cnt));
    chk("sel_value", 32'(sel_val), 32'(e.sel));
    n_vec++;
    if (win_len < int'(e.lat_min) || win_len > int'(e.lat_max)) begin
      n_bad++;
      $display("FAIL busy_cycles: got %0d, expected %0d..%0d", win_len, e.lat_min, e.lat_max);
    end
  endtask

  always @(negedge clk) begin
    if (rst_s) begin
      chk("reset_state",
          {19'd0, state_dbg, busy, mov_sel, perdio, gano, (move_count == 16'd0), (board == '0)},
          {19'd0, ST_INIT_A, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1});
      win_len = 0;
      sel_cnt = 0;
      sel_val = 3'b000;
    end else begin
      if (busy === 1'b1) begin
        win_len++;
        if (mov_sel != 3'b000) begin
          sel_cnt++;
          sel_val = mov_sel;
        end
      end
      if (prev_busy && !busy) begin
        check_output();
        snap    = board;
        snap_mc = move_count;
        win_len = 0;
        sel_cnt = 0;
        sel_val = 3'b000;
      end else if (!prev_busy && !busy) begin
        chk("quiet_cycle", {27'd0, (board == snap), (move_count == snap_mc), mov_sel},
            {27'd0, 1'b1, 1'b1, 3'b000});
      end
    end
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [2:0] st, input logic g, input logic p,
                          input logic [15:0] mc, input logic rp, input logic [255:0] rb,
                          input logic [4:0] nt, input logic [2:0] sel, input logic [1:0] sc,
                          input logic [5:0] lmin, input logic [5:0] lmax);
    exp_t e;
    e.state = st; e.gano = g; e.perdio = p; e.mc = mc; e.ref_prev = rp;
    e.ref_board = rb; e.new_tiles = nt; e.sel = sel; e.sel_cnt = sc;
    e.lat_min = lmin; e.lat_max = lmax;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_exp(ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0, '0, 5'd2, 3'b000, 2'd0, 6'd3, 6'd34);
  endtask

  task automatic move(input logic [2:0] d);
    @(negedge clk);
    btn_valid = 1'b1;
    btn_dir   = d;
    @(negedge clk);
    btn_valid = 1'b0;
    btn_dir   = 3'b000;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d outputs pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int t = 0;
    while (state_dbg != s && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (state_dbg != s) begin
      n_bad++;
      $display("FAIL %s_timeout: got state %0d, expected %0d", name, state_dbg, s);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [255:0] set_cell(input logic [255:0] b, input int i, input logic [15:0] v);
    b[i*16 +: 16] = v;
    return b;
  endfunction

  // ---------------- stimulus ----------------
  logic [255:0] b;

  initial begin
    // power-up: two reset cycles, then two tiles placed
    push_init();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain("init");

    // echo datapath, left: no change, one APPLY cycle
    push_exp(ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b1, '0, 5'd0, 3'b011, 2'd1, 6'd1, 6'd1);
    move(3'b011);
    wait_drain("echo_left");

    // illegal codes are dropped (quiet cycles must stay quiet)
    move(3'b000);
    move(3'b101);
    move(3'b110);
    move(3'b111);
    repeat (3) @(negedge clk);

    // datapath returns a single 4 at cell 0
    b = set_cell('0, 0, 16'd4);
    fixed_board = b;
    use_fixed   = 1'b1;
    push_exp(ST_IDLE, 1'b0, 1'b0, 16'd1, 1'b0, b, 5'd1, 3'b001, 2'd1, 6'd3, 6'd18);
    move(3'b001);
    wait_drain("single_tile");
    use_fixed = 1'b0;

    // echo right: unchanged, count holds
    push_exp(ST_IDLE, 1'b0, 1'b0, 16'd1, 1'b1, '0, 5'd0, 3'b100, 2'd1, 6'd1, 6'd1);
    move(3'b100);
    wait_drain("echo_right");

    // full board with a mergeable pair: 16-cell scan, no tile, back to IDLE
    b = '0;
    for (int i = 0; i < 14; i++) b = set_cell(b, i, 16'(16 + i));
    b = set_cell(b, 14, 16'd100);
    b = set_cell(b, 15, 16'd100);
    fixed_board = b;
    use_fixed   = 1'b1;
    push_exp(ST_IDLE, 1'b0, 1'b0, 16'd2, 1'b0, b, 5'd0, 3'b010, 2'd1, 6'd18, 6'd18);
    move(3'b010);
    wait_drain("full_board");

    // only cell 15 free; a strobe during SPAWN must be ignored
    b = '0;
    b = set_cell(b, 0, 16'd64);
    b = set_cell(b, 1, 16'd64);
    for (int i = 2; i < 15; i++) b = set_cell(b, i, 16'(16 + i));
    fixed_board = b;
    push_exp(ST_IDLE, 1'b0, 1'b0, 16'd3, 1'b0, b, 5'd1, 3'b011, 2'd1, 6'd3, 6'd18);
    move(3'b011);
    wait_state(ST_SPAWN, "spawn_reach");
    btn_valid = 1'b1;
    btn_dir   = 3'b001;
    @(negedge clk);
    btn_valid = 1'b0;
    btn_dir   = 3'b000;
    wait_drain("btn_in_spawn");

    // reset in the middle of SPAWN: board cleared, INIT re-runs
    b = set_cell('0, 0, 16'd4);
    fixed_board = b;
    move(3'b001);
    wait_state(ST_SPAWN, "abort_reach");
    push_init();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    use_fixed = 1'b0;
    wait_drain("abort_init");

    // loss: only cell 0 free, no pairs, neighbours of cell 0 hold 8
    b = '0;
    for (int i = 2; i < 16; i++) b = set_cell(b, i, 16'(16 + i));
    b = set_cell(b, 1, 16'd8);
    b = set_cell(b, 4, 16'd8);
    fixed_board = b;
    use_fixed   = 1'b1;
    push_exp(ST_LOSE, 1'b0, 1'b1, 16'd1, 1'b0, b, 5'd1, 3'b010, 2'd1, 6'd3, 6'd18);
    move(3'b010);
    wait_drain("lose");
    move(3'b001);
    repeat (3) @(negedge clk);

    // win: 2048 at cell 5, then strobes have no effect
    push_init();
    pulse_reset();
    use_fixed = 1'b0;
    wait_drain("reinit_win");
    b = set_cell('0, 5, 16'd2048);
    fixed_board = b;
    use_fixed   = 1'b1;
    push_exp(ST_WIN, 1'b1, 1'b0, 16'd1, 1'b0, b, 5'd1, 3'b001, 2'd1, 6'd3, 6'd18);
    move(3'b001);
    wait_drain("win");
    fixed_board = set_cell('0, 3, 16'd8);
    move(3'b011);
    move(3'b100);
    repeat (3) @(negedge clk);

    // reset leaves WIN and clears gano
    use_fixed = 1'b0;
    push_init();
    pulse_reset();
    wait_drain("reinit_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000ns");
    $fatal(1);
  end

endmodule
